// File: rtl/text_overlay_pkg.sv
// rtl/text_overlay_pkg.sv - shared constants, clear FSM state type and 8x8 font for text_overlay
package text_pkg;

   localparam logic [7:0] FONT_FIRST = 8'h20;
   localparam logic [7:0] FONT_LAST  = 8'h5A;
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam int         FONT_N     = 59;

   typedef enum logic {IDLE, CLEAR} state_t;

   // One 64-bit word per glyph: row 0 in the top byte, bit 7 of a row is the leftmost pixel.
   localparam logic [0:FONT_N-1][0:7][7:0] FONT = {
      64'h0000000000000000, 64'h183C3C1818001800, 64'h6C6C000000000000, 64'h6C6CFE6CFE6C6C00,
      64'h307CC0780CF83000, 64'h00C6CC183066C600, 64'h386C3876DCCC7600, 64'h6060C00000000000,
      64'h1830606060301800, 64'h6030181818306000, 64'h00663CFF3C660000, 64'h003030FC30300000,
      64'h0000000030306000, 64'h000000FC00000000, 64'h0000000000303000, 64'h060C183060C08000,
      64'h7CC6CEDEF6E67C00, 64'h307030303030FC00, 64'h78CC0C3860CCFC00, 64'h78CC0C380CCC7800,
      64'h1C3C6CCCFE0C1E00, 64'hFCC0F80C0CCC7800, 64'h3860C0F8CCCC7800, 64'hFCCC0C1830303000,
      64'h78CCCC78CCCC7800, 64'h78CCCC7C0C187000, 64'h0030300000303000, 64'h0030300030306000,
      64'h183060C060301800, 64'h0000FC0000FC0000, 64'h6030180C18306000, 64'h78CC0C1830003000,
      64'h7CC6DEDEDEC07800, 64'h3078CCCCFCCCCC00, 64'hFC66667C6666FC00, 64'h3C66C0C0C0663C00,
      64'hF86C6666666CF800, 64'hFE6268786862FE00, 64'hFE6268786860F000, 64'h3C66C0C0CE663E00,
      64'hCCCCCCFCCCCCCC00, 64'h7830303030307800, 64'h1E0C0C0CCCCC7800, 64'hE6666C786C66E600,
      64'hF06060606266FE00, 64'hC6EEFEFED6C6C600, 64'hC6E6F6DECEC6C600, 64'h386CC6C6C66C3800,
      64'hFC66667C6060F000, 64'h78CCCCCCDC781C00, 64'hFC66667C6C66E600, 64'h78CCE0701CCC7800,
      64'hFCB4303030307800, 64'hCCCCCCCCCCCCFC00, 64'hCCCCCCCCCC783000, 64'hC6C6C6D6FEEEC600,
      64'hC6C66C38386CC600, 64'hCCCCCC7830307800, 64'hFEC68C183266FE00
   };

endpackage

// File: rtl/text_overlay_if.sv
// rtl/text_overlay_if.sv - character buffer write/clear bus between game logic and text_overlay
interface text_overlay_if #(
   parameter int COLS = 40,
   parameter int ROWS = 4
);
   logic                    wr_en;
   logic [$clog2(COLS)-1:0] wr_col;
   logic [$clog2(ROWS)-1:0] wr_row;
   logic [7:0]              wr_char;
   logic                    clr_req;
   logic                    busy;

   modport master (output wr_en, wr_col, wr_row, wr_char, clr_req, input busy);
   modport slave  (input wr_en, wr_col, wr_row, wr_char, clr_req, output busy);
endinterface

// File: rtl/text_overlay_font_rom.sv
// rtl/text_overlay_font_rom.sv - combinational glyph row lookup; codes outside the font give 0
module font_rom
   import text_pkg::*;
(
   input  logic [7:0] code,
   input  logic [2:0] row,
   output logic [7:0] bitmap
);
   logic [5:0] idx;

   always_comb begin
      bitmap = 8'h00;
      idx    = 6'(code - FONT_FIRST);
      if (code >= FONT_FIRST && code <= FONT_LAST)
         bitmap = FONT[idx][row];
   end
endmodule

// File: rtl/text_overlay.sv
// rtl/text_overlay.sv - buffered COLSxROWS text renderer with auto-clear FSM, 2-cycle pixel latency
// Optional blink attribute in wr_char[7] when TEXT_BLINK_EN is defined.
module text_overlay
   import text_pkg::*;
#(
   parameter int COLS         = 40,
   parameter int ROWS         = 4,
   parameter int SCALE        = 2,
   parameter int ORIGIN_X     = 0,
   parameter int ORIGIN_Y     = 0,
   parameter int BLINK_PERIOD = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [9:0]       draw_x,
   input  logic [9:0]       draw_y,
   input  logic             frame_start,
   text_overlay_if.slave    wr,
   output logic             pixel_on
);
   localparam int DEPTH = COLS * ROWS;
   localparam int AW    = $clog2(DEPTH);
   localparam int SSH   = $clog2(SCALE);
   localparam int CSH   = SSH + 3;
   localparam int WIN_W = COLS * 8 * SCALE;
   localparam int WIN_H = ROWS * 8 * SCALE;

   state_t          state, state_nx;
   logic [AW-1:0]   idx, idx_nx;
   logic            wr_ok;
   logic            mem_we;
   logic [AW-1:0]   mem_waddr;
   logic [7:0]      mem_wdata;
   logic [7:0]      buffer [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      case (state)
         IDLE: begin
            if (wr.clr_req) begin
               state_nx = CLEAR;
               idx_nx   = '0;
            end
         end
         default: begin
            if (idx == AW'(DEPTH - 1)) begin
               state_nx = IDLE;
               idx_nx   = '0;
            end else begin
               idx_nx = idx + 1'b1;
            end
         end
      endcase
   end

   // clr_req wins over a same-cycle write; everything from the bus is ignored while sweeping.
   always_comb begin
      wr_ok     = (int'(wr.wr_col) < COLS) && (int'(wr.wr_row) < ROWS);
      wr.busy   = (state == CLEAR);
      mem_we    = wr.wr_en & ~wr.clr_req & wr_ok;
      mem_waddr = AW'(int'(wr.wr_row) * COLS + int'(wr.wr_col));
      mem_wdata = wr.wr_char;
      if (state == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = idx;
         mem_wdata = CHAR_SPACE;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         buffer[mem_waddr] <= mem_wdata;
   end

   logic [9:0]    rx, ry;
   logic          in_win;
   logic [AW-1:0] raddr;
   logic          s1_valid;
   logic [7:0]    s1_char;
   logic [2:0]    s1_gcol, s1_grow;

   always_comb begin
      rx     = draw_x - 10'(ORIGIN_X);
      ry     = draw_y - 10'(ORIGIN_Y);
      in_win = (int'(draw_x) >= ORIGIN_X) && (int'(draw_x) < ORIGIN_X + WIN_W) &&
               (int'(draw_y) >= ORIGIN_Y) && (int'(draw_y) < ORIGIN_Y + WIN_H);
      raddr  = '0;
      if (in_win)
         raddr = AW'(int'(ry >> CSH) * COLS + int'(rx >> CSH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) s1_valid <= 1'b0;
      else        s1_valid <= in_win;
   end

   // Read-before-write: a same-edge write to this entry shows up one read later.
   always_ff @(posedge clk) begin
      s1_char <= buffer[raddr];
      s1_gcol <= rx[SSH +: 3];
      s1_grow <= ry[SSH +: 3];
   end

   logic [7:0] glyph_code;
   logic [7:0] glyph_bits;
   logic       blanked;

`ifdef TEXT_BLINK_EN
   logic [15:0] frame_cnt;
   logic        blink_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_start) begin
         if (frame_cnt == 16'(BLINK_PERIOD - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   assign glyph_code = {1'b0, s1_char[6:0]};
   assign blanked    = s1_char[7] & blink_phase;
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start;
   assign glyph_code         = s1_char;
   assign blanked            = 1'b0;
`endif

   font_rom u_font (
      .code   (glyph_code),
      .row    (s1_grow),
      .bitmap (glyph_bits)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pixel_on <= 1'b0;
      else        pixel_on <= s1_valid & glyph_bits[3'd7 - s1_gcol] & ~blanked;
   end
endmodule

// File: tb/tb_text_overlay.sv
// tb/tb_text_overlay.sv - scoreboard bench for text_overlay (COLS=40, ROWS=4, SCALE=2, origin 0)
module tb_text_overlay;
   localparam int COLS = 40;
   localparam int ROWS = 4;
   localparam int BP   = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] draw_x = '0;
   logic [9:0] draw_y = '0;
   logic       frame_start = 1'b0;
   logic       pixel_on;

   text_overlay_if #(.COLS(COLS), .ROWS(ROWS)) wif ();

   text_overlay #(
      .COLS(COLS), .ROWS(ROWS), .SCALE(2), .ORIGIN_X(0), .ORIGIN_Y(0), .BLINK_PERIOD(BP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .draw_x      (draw_x),
      .draw_y      (draw_y),
      .frame_start (frame_start),
      .wr          (wif),
      .pixel_on    (pixel_on)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
   endtask

   typedef struct {
      int    due;
      logic  exp;
      string tag;
   } sb_t;
   sb_t sb[$];

   logic [7:0] ref_buf [COLS*ROWS];
   int frames = 0;
   logic [7:0] a_glyph [8] = '{8'h30, 8'h78, 8'hCC, 8'hCC, 8'hFC, 8'hCC, 8'hCC, 8'h00};

   function automatic logic exp_pix(int x, int y);
      logic [7:0] c;
      int gc, gr;
      if (x >= COLS * 16 || y >= ROWS * 16) return 1'b0;
      c  = ref_buf[(y / 16) * COLS + x / 16];
      gc = (x / 2) % 8;
      gr = (y / 2) % 8;
`ifdef TEXT_BLINK_EN
      if (c[7] && ((frames / BP) % 2 == 1)) return 1'b0;
      c[7] = 1'b0;
`endif
      if (c == 8'h41) return a_glyph[gr][7 - gc];
      return 1'b0;
   endfunction

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cycle) begin
         sb_t e;
         e = sb.pop_front();
         if (e.due == cycle) check(e.tag, pixel_on, e.exp);
         else check("sb_late", cycle, e.due);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int x, int y, string tag);
      draw_x = 10'(x);
      draw_y = 10'(y);
      sb.push_back('{cycle + 2, exp_pix(x, y), tag});
   endtask

   task automatic sweep(int x0, int x1, int y, string tag);
      for (int x = x0; x <= x1; x++) begin
         tick();
         drive(x, y, tag);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
      check("drain", sb.size(), 0);
   endtask

   task automatic wr(int col, int row, logic [7:0] ch, bit ok);
      tick();
      wif.wr_en   = 1'b1;
      wif.wr_col  = 6'(col);
      wif.wr_row  = 2'(row);
      wif.wr_char = ch;
      tick();
      wif.wr_en = 1'b0;
      if (ok) ref_buf[row * COLS + col] = ch;
   endtask

   task automatic wait_clear(string tag);
      int cnt;
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (wif.busy && cnt < 1000);
      check({tag, "_clear_cycles"}, cnt, 160);
      for (int i = 0; i < COLS * ROWS; i++) ref_buf[i] = 8'h20;
   endtask

   task automatic do_reset(string tag);
      rst_n = 1'b0;
      tick();
      tick();
      check({tag, "_busy_in_rst"}, wif.busy, 1);
      check({tag, "_pix_in_rst"}, pixel_on, 0);
      rst_n = 1'b1;
      wait_clear(tag);
   endtask

   initial begin
      wif.wr_en   = 1'b0;
      wif.wr_col  = '0;
      wif.wr_row  = '0;
      wif.wr_char = '0;
      wif.clr_req = 1'b0;

      do_reset("por");
      foreach (sb[i]) sb.delete();
      for (int k = 0; k < 4; k++) sweep(0, 650, (k == 3) ? 63 : k * 10 + 1, "blank");
      drain();

      wr(0, 0, 8'h41, 1);
      for (int y = 0; y < 16; y++) sweep(0, 15, y, "a_cell");
      drain();

      wr(39, 3, 8'h41, 1);
      for (int k = 0; k < 5; k++) sweep(620, 645, (k == 4) ? 64 : 48 + k * 5, "edge");
      sweep(636, 641, 63, "edge63");
      tick();
      drive(0, 64, "edge_below");
      drain();

      // Same-edge write and read of one entry: old data first, new data next cycle.
      tick();
      wif.wr_en = 1'b1; wif.wr_col = 6'd7; wif.wr_row = 2'd0; wif.wr_char = 8'h41;
      drive(7 * 16 + 4, 0, "rw_old");
      ref_buf[7] = 8'h41;
      tick();
      wif.wr_en = 1'b0;
      drive(7 * 16 + 4, 0, "rw_new");
      drain();

      wr(45, 0, 8'h41, 0);
      sweep(64, 111, 16, "col_oob");
      sweep(64, 111, 18, "col_oob");
      drain();

      wr(1, 1, 8'h7B, 1);
      wr(2, 1, 8'h1F, 1);
      wr(3, 1, 8'hC1, 1);
      for (int y = 16; y < 32; y++) sweep(16, 63, y, "codes");
      drain();

      tick();
      wif.clr_req = 1'b1; wif.wr_en = 1'b1; wif.wr_col = 6'd5; wif.wr_row = 2'd0; wif.wr_char = 8'h41;
      tick();
      wif.clr_req = 1'b0; wif.wr_col = 6'd6;
      check("busy_after_clr", wif.busy, 1);
      tick();
      wif.wr_en = 1'b0;
      repeat (40) tick();
      check("busy_mid_clear", wif.busy, 1);
      do_reset("mid");
      sweep(0, 127, 0, "after_clr");
      sweep(0, 127, 2, "after_clr");
      drain();

      wr(0, 0, 8'h41, 1);
      tick();
      wif.clr_req = 1'b1;
      tick();
      wif.clr_req = 1'b0;
      wait_clear("clr");
      sweep(0, 15, 2, "cleared");
      drain();

`ifdef TEXT_BLINK_EN
      wr(10, 0, 8'hC1, 1);
      wr(11, 0, 8'h41, 1);
      for (int f = 0; f < 5; f++) begin
         for (int y = 0; y < 16; y += 2) sweep(160, 191, y, "blink");
         drain();
         tick();
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         frames++;
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/text_overlay.md
# text_overlay

Parametrised character-cell text renderer that sits between the VGA timing generator and the colour mux. It holds a COLS×ROWS character buffer that the game logic writes, and it renders the buffer as 8×8 glyphs scaled by SCALE at a fixed screen origin. It drives a registered `pixel_on` two cycles after the pixel coordinate. An auto-clear state machine and an optional blink attribute replace the fixed, unbuffered glyph lookup of the previous generation.

## Interface
Parameters:
- COLS, 40, character columns in the buffer.
- ROWS, 4, character rows in the buffer.
- SCALE, 2, integer pixel magnification; legal values are 1, 2, 4, 8.
- ORIGIN_X, 0, screen x of the top-left pixel of cell (0,0).
- ORIGIN_Y, 0, screen y of the top-left pixel of cell (0,0).
- BLINK_PERIOD, 32, frames per blink phase; used only with TEXT_BLINK_EN.

Ports:
- clk  in  1  pixel clock; this is the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- draw_x  in  10  current pixel x from the VGA controller.
- draw_y  in  10  current pixel y from the VGA controller.
- frame_start  in  1  one-cycle pulse per frame.
- wr_en  in  1  buffer write strobe.
- wr_col  in  $clog2(COLS)  write column.
- wr_row  in  $clog2(ROWS)  write row.
- wr_char  in  8  ASCII code to write (bit 7 is the blink attribute when TEXT_BLINK_EN is defined).
- clr_req  in  1  request a full buffer clear.
- busy  out  1  clear sweep in progress; writes are dropped while high.
- pixel_on  out  1  the current pixel is a lit glyph pixel.

## Operation
- The font covers codes 0x20–0x5A.
  - Glyph rows 0–6 carry the bitmap; row 7 is always 0.
  - Bit 7 of each glyph row is the leftmost glyph column.
  - Any code outside 0x20–0x5A renders blank.
- The clear FSM has two states, IDLE and CLEAR.
- CLEAR state:
  - A linear index runs from 0 to COLS*ROWS-1. Each cycle the entry at that index is written with 0x20.
  - `busy` is 1 throughout CLEAR.
  - When the index reaches COLS*ROWS-1, that last write still happens and the FSM moves to IDLE on the next edge.
- IDLE state:
  - `wr_en` writes `wr_char` to entry wr_row*COLS+wr_col on the same edge.
  - Writes with wr_col ≥ COLS or wr_row ≥ ROWS are ignored.
  - `clr_req` moves the FSM to CLEAR with index 0. If `wr_en` is high on the same cycle, `clr_req` wins and the write is dropped.
- During CLEAR, both `wr_en` and `clr_req` are ignored.
- Window test:
  - The text window is ORIGIN_X ≤ x < ORIGIN_X+COLS*8*SCALE and ORIGIN_Y ≤ y < ORIGIN_Y+ROWS*8*SCALE.
  - Outside the window `pixel_on` is 0.
- Cell and glyph arithmetic, with rx = x−ORIGIN_X and ry = y−ORIGIN_Y, both unsigned and valid only inside the window:
  - cell column = rx >> log2(8*SCALE); cell row = ry >> log2(8*SCALE).
  - glyph column = (rx >> log2(SCALE)) & 7; glyph row = (ry >> log2(SCALE)) & 7.
- While `busy` is high, rendering continues and shows whatever the buffer holds.

## Timing
- Reset (asynchronous assertion, synchronous release):
  - FSM enters CLEAR with index 0, so `busy` = 1.
  - `pixel_on` = 0, the pipeline valid bits are 0 and the blink state is 0.
  - The buffer is not reset; the automatic CLEAR after reset defines it within COLS*ROWS cycles.
- Pipeline stage 1 registers the window flag, the glyph row/column and the synchronous buffer read.
- Pipeline stage 2 does the font lookup and bit select, then registers `pixel_on`.
- Latency from draw_x/draw_y to `pixel_on` is exactly 2 cycles.
- The renderer has one coordinate per cycle of throughput and no stalls.
- A read and a write to the same entry in the same cycle returns the old data. The new character is visible from the next read cycle.
- Reset asserted mid-CLEAR restarts the sweep at index 0.

## Configuration
- Macro TEXT_BLINK_EN.
- Defined:
  - wr_char[7] is stored as a blink attribute; glyph selection uses wr_char[6:0].
  - A frame counter counts `frame_start` pulses and toggles a blink phase every BLINK_PERIOD pulses.
  - While the phase is 1, cells with the attribute set render blank.
  - Clear writes 0x20, i.e. blink off.
- Undefined:
  - All 8 bits are the character code, so codes ≥ 0x80 render blank.
  - `frame_start` is unused.
  - No blink counter is synthesised.

## Structure
- Package text_pkg holds:
  - constants FONT_FIRST = 8'h20, FONT_LAST = 8'h5A and CHAR_SPACE = 8'h20;
  - the packed font constant array (59 glyphs × 8 rows × 8 bits);
  - the FSM state enum (IDLE, CLEAR).
- Sub-module font_rom: combinational lookup of code[7:0] and row[2:0] to bitmap[7:0], returning 0 for any code out of range; instantiated in stage 2.

## Test plan
- Reset with defaults: `busy` stays 1 for 160 cycles, then goes 0; every cell then reads 0x20 and `pixel_on` is 0 everywhere.
- Write 0x41 ('A') to col 0, row 0 (SCALE=2, origin 0), then sweep y=0 over x=0..15: `pixel_on` is high exactly for x=4..7, each result two cycles after its coordinate; at y=14 and 15 (glyph row 7) it is always 0.
- Place 'A' in cell (39,3) and present coordinates (639,63), (640,63) and (0,64): only in-window pixels can be lit; (640,63) and (0,64) give 0.
- Assert `clr_req` and `wr_en` together, then `wr_en` while `busy`, then reset mid-CLEAR: both writes are dropped, the sweep restarts at index 0 after reset, and `busy` clears 160 cycles after the last restart.
- Write codes 0x7B and 0x1F: both render blank in all 64 glyph pixels.
- With TEXT_BLINK_EN and BLINK_PERIOD=2, write 0xC1: the 'A' pixels are lit during frames 0–1, blank during frames 2–3 and lit again in frame 4; 0x41 written to another cell stays lit throughout.
